// File: rtl/mem_io_ctrl.sv
// Memory-side responder for the CPU byte bus: 128KB RAM plus an I/O window
// at 0x30000 with RX/TX byte FIFOs, a free-running cycle counter and a halt flag.
module mem_io_ctrl #(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        cpu_rdy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted
);
   localparam int FD = 1 << FIFO_AW;

   logic [7:0]       ram    [2**RAM_AW];
   logic [7:0]       rx_mem [FD];
   logic [7:0]       tx_mem [FD];
   logic [FIFO_AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic [31:0]      counter, snapshot;

   logic        rx_empty, rx_full, tx_empty, tx_full;
   logic        is_io, bus_wr, bus_rd, ram_we, halt_wr;
   logic        rx_push, rx_pop, tx_push, tx_pop;
   logic [15:0] io_off;
   logic [7:0]  tx_din, rd_data;
   logic        unused_hi;

   assign unused_hi = ^mem_a[31:18];

   // Same low bits with differing MSBs means the writer lapped the reader.
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                     (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                     (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);

   assign cpu_rdy  = ~tx_full;
   assign rx_ready = ~rx_full;
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[FIFO_AW-1:0]];

   assign is_io   = (mem_a[17:16] == 2'b11);
   assign io_off  = mem_a[15:0];
   assign bus_wr  = cpu_rdy & mem_wr;
   assign bus_rd  = cpu_rdy & ~mem_wr;
   assign ram_we  = bus_wr & ~is_io;
   assign halt_wr = bus_wr & is_io & (io_off == 16'h0004);

   assign rx_push = rx_valid & ~rx_full;
   assign rx_pop  = bus_rd & is_io & (io_off == 16'h0000) & ~rx_empty;
   assign tx_push = halt_wr |
                    (bus_wr & is_io & (io_off == 16'h0000) &
                     (mem_dout != 8'h00));
   assign tx_din  = halt_wr ? 8'h00 : mem_dout;
   assign tx_pop  = tx_valid & tx_ready;

   always_comb begin
      rd_data = 8'h00;
      if (!is_io) begin
         rd_data = ram[mem_a[RAM_AW-1:0]];
      end else begin
         unique case (io_off)
            16'h0000: rd_data = rx_empty ? 8'h00
                                         : rx_mem[rx_rp[FIFO_AW-1:0]];
            16'h0004: rd_data = counter[7:0];
            16'h0005: rd_data = snapshot[15:8];
            16'h0006: rd_data = snapshot[23:16];
            16'h0007: rd_data = snapshot[31:24];
            default:  rd_data = 8'h00;
         endcase
      end
   end

   // Storage arrays carry no reset; only the pointers define FIFO contents.
   always_ff @(posedge clk_in) begin
      if (ram_we)
         ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      if (rx_push)
         rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data;
      if (tx_push)
         tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_din;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_din  <= 8'h00;
         halted   <= 1'b0;
         counter  <= 32'h0;
         snapshot <= 32'h0;
         rx_wp    <= '0;
         rx_rp    <= '0;
         tx_wp    <= '0;
         tx_rp    <= '0;
      end else begin
         counter <= counter + 32'h1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (halt_wr) halted <= 1'b1;
         if (bus_rd) begin
            mem_din <= rd_data;
            if (is_io && io_off == 16'h0004)
               snapshot <= counter;
         end
      end
   end
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: queue/array reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_io_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = 32'h0003_0010;
   logic [7:0]  mem_dout = 8'h00;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        cpu_rdy;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        halted;

   int n_checks = 0;
   int n_errs = 0;
   bit cmp_en = 0;

   mem_io_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .cpu_rdy(cpu_rdy), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .halted(halted)
   );

   always #5 clk_in = ~clk_in;

   // Reference model
   logic [7:0]  mram [131072];
   logic [7:0]  rxq [$];
   logic [7:0]  txq [$];
   logic [7:0]  m_din;
   logic        m_halt;
   logic [31:0] m_cnt, m_snap;

   always @(posedge clk_in or posedge rst_in) begin : mdl
      int   rxn;
      bit   rdy, io;
      logic [15:0] off;
      if (rst_in) begin
         rxq.delete(); txq.delete();
         m_din = 0; m_halt = 0; m_cnt = 0; m_snap = 0;
      end else begin
         rxn = rxq.size();
         rdy = (txq.size() < 16);
         io  = (mem_a[17:16] == 2'b11);
         off = mem_a[15:0];
         if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
         if (rdy && mem_wr) begin
            if (!io) mram[mem_a[16:0]] = mem_dout;
            else if (off == 0 && mem_dout != 0) txq.push_back(mem_dout);
            else if (off == 4) begin m_halt = 1; txq.push_back(8'h00); end
         end else if (rdy) begin
            if (!io) m_din = mram[mem_a[16:0]];
            else case (off)
               16'h0000: m_din = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
               16'h0004: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
               16'h0005: m_din = m_snap[15:8];
               16'h0006: m_din = m_snap[23:16];
               16'h0007: m_din = m_snap[31:24];
               default:  m_din = 8'h00;
            endcase
         end
         if (rx_valid && rxn < 16) rxq.push_back(rx_data);
         m_cnt = m_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      if (cmp_en) begin
         chk("mem_din", mem_din, m_din);
         chk("cpu_rdy", cpu_rdy, txq.size() < 16);
         chk("rx_ready", rx_ready, rxq.size() < 16);
         chk("tx_valid", tx_valid, txq.size() > 0);
         chk("tx_data", tx_data, (txq.size() > 0) ? txq[0] : 8'h00);
         chk("halted", halted, m_halt);
      end
   end

   task automatic cyc(input logic w, input logic [31:0] a,
                      input logic [7:0] d, input logic rv,
                      input logic [7:0] rd, input logic tr);
      mem_wr = w; mem_a = a; mem_dout = d;
      rx_valid = rv; rx_data = rd; tx_ready = tr;
      @(posedge clk_in); #1;
   endtask

   task automatic idle(input logic tr);
      cyc(0, 32'h0003_0010, 8'h00, 0, 8'h00, tr);
   endtask

   task automatic cnt_read(input logic [31:0] val);
      mem_wr = 0; mem_a = 32'h0003_0004; rx_valid = 0; tx_ready = 0;
      @(negedge clk_in);
      force dut.counter = val;
      m_cnt = val;
      #1 release dut.counter;
      @(posedge clk_in); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      #2 rst_in = 1;
      @(posedge clk_in); #1;
      chk("rst_mem_din", mem_din, 8'h00);
      chk("rst_cpu_rdy", cpu_rdy, 1'b1);
      chk("rst_rx_ready", rx_ready, 1'b1);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_halted", halted, 1'b0);
      @(posedge clk_in); #1;
      rst_in = 0;
      cmp_en = 1;

      for (int i = 0; i < 64; i++)
         cyc(1, i, 8'(i ^ 8'h5C), 0, 8'h00, 0);

      // RAM write then read
      cyc(1, 32'h10, 8'hA5, 0, 8'h00, 0);
      cyc(0, 32'h10, 8'h00, 0, 8'h00, 0);
      chk("t1_ram_rd", mem_din, 8'hA5);

      // RX FIFO pops, then empty read
      idle(0);
      cyc(0, 32'h0003_0010, 8'h00, 1, 8'h31, 0);
      cyc(0, 32'h0003_0010, 8'h00, 1, 8'h32, 0);
      cyc(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
      chk("t2_rx0", mem_din, 8'h31);
      cyc(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
      chk("t2_rx1", mem_din, 8'h32);
      cyc(0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
      chk("t2_rx_empty", mem_din, 8'h00);
      chk("t2_rx_ready", rx_ready, 1'b1);

      // TX zero drop, fill, stall, single acceptance
      cyc(1, 32'h0003_0000, 8'h41, 0, 8'h00, 0);
      cyc(1, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
      cyc(1, 32'h0003_0000, 8'h42, 0, 8'h00, 0);
      chk("t3_head41", tx_data, 8'h41);
      idle(1);
      chk("t3_head42", tx_data, 8'h42);
      idle(1);
      chk("t3_tx_empty", tx_valid, 1'b0);
      for (int i = 1; i <= 16; i++)
         cyc(1, 32'h0003_0000, 8'(i), 0, 8'h00, 0);
      chk("t3_stall", cpu_rdy, 1'b0);
      cyc(1, 32'h0003_0000, 8'h77, 0, 8'h00, 0);
      chk("t3_still_stall", cpu_rdy, 1'b0);
      cyc(1, 32'h0003_0000, 8'h77, 0, 8'h00, 1);
      chk("t3_resume", cpu_rdy, 1'b1);
      cyc(1, 32'h0003_0000, 8'h77, 0, 8'h00, 0);
      chk("t3_refull", cpu_rdy, 1'b0);
      for (int i = 0; i < 15; i++) idle(1);
      chk("t3_last77", tx_data, 8'h77);
      idle(1);
      chk("t3_drained", tx_valid, 1'b0);

      // Counter snapshot and wrap
      cnt_read(32'h0102_0304);
      chk("t4_b0", mem_din, 8'h04);
      cyc(0, 32'h0003_0005, 8'h00, 0, 8'h00, 0);
      chk("t4_b1", mem_din, 8'h03);
      cyc(0, 32'h0003_0006, 8'h00, 0, 8'h00, 0);
      chk("t4_b2", mem_din, 8'h02);
      cyc(0, 32'h0003_0007, 8'h00, 0, 8'h00, 0);
      chk("t4_b3", mem_din, 8'h01);
      cnt_read(32'hFFFF_FFFF);
      chk("t4_wrap_ff", mem_din, 8'hFF);
      cyc(0, 32'h0003_0004, 8'h00, 0, 8'h00, 0);
      chk("t4_wrap_00", mem_din, 8'h00);
      cyc(0, 32'h0003_0007, 8'h00, 0, 8'h00, 0);
      chk("t4_wrap_hi", mem_din, 8'h00);

      // Halt
      cyc(1, 32'h0003_0004, 8'h99, 0, 8'h00, 0);
      chk("t5_halted", halted, 1'b1);
      chk("t5_tx_zero_v", tx_valid, 1'b1);
      chk("t5_tx_zero", tx_data, 8'h00);
      cyc(1, 32'h20, 8'h5A, 0, 8'h00, 0);
      cyc(0, 32'h20, 8'h00, 0, 8'h00, 1);
      chk("t5_ram_after_halt", mem_din, 8'h5A);

      // Async reset with both FIFOs partly filled
      for (int i = 0; i < 8; i++)
         cyc(1, 32'h0003_0000, 8'(8'h60 + i), 1, 8'(8'h70 + i), 0);
      @(negedge clk_in); #2;
      rst_in = 1;
      #1;
      chk("t6_tx_valid", tx_valid, 1'b0);
      chk("t6_rx_ready", rx_ready, 1'b1);
      chk("t6_halted", halted, 1'b0);
      chk("t6_mem_din", mem_din, 8'h00);
      chk("t6_cpu_rdy", cpu_rdy, 1'b1);
      @(posedge clk_in); #1;
      rst_in = 0;
      cyc(0, 32'h20, 8'h00, 0, 8'h00, 0);
      chk("t6_ram_kept", mem_din, 8'h5A);
      cyc(0, 32'h0003_0004, 8'h00, 0, 8'h00, 0);
      chk("t6_cnt_reset", mem_din, 8'h01);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0)
            a = {$urandom_range(0, 16383) & 32'h3FFF, 2'b11,
                 16'($urandom_range(0, 8))};
         else
            a = {$urandom_range(0, 16383) & 32'h3FFF,
                 1'($urandom_range(0, 1)), 1'b0, 10'h0,
                 6'($urandom_range(0, 63))};
         cyc(1'($urandom_range(0, 1)), a,
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
             1'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 9) < 3));
      end
      idle(0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errs);
      $finish;
   end
endmodule
